phase_timer: RTL and testbench
==============================

Name: phase_timer

Overview:
- Cycle timer that sits directly downstream of the per-phase count lookup and upstream of the washer controller FSM.
- Watches the controller's 3-bit phase code and detects entry into a timed phase.
- On entry, loads the phase's count value and counts it down, with pause support.
- Returns a one-cycle timeout pulse so the controller can advance to the next phase.

Parameters:
- CNT_W, 32, width of the count input and the internal down-counter.
- TIMED_MASK, 8'b1100_1010, bit i set = phase code i is timed (001 fill, 011 wash, 110 rinse, 111 spin).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous reset, active-high.
- state_in  input  3  current phase code from the controller.
- counts_num  input  CNT_W  cycle count for the current phase/clock-frequency combination. Combinational from state_in, so it is valid in the same cycle.
- pause  input  1  high = freeze countdown (door open / user pause).
- timeout  output  1  one-cycle pulse when the phase time has elapsed.
- busy  output  1  high while a countdown is loaded and not yet expired (includes paused).
- remaining  output  CNT_W  current down-counter value.

Behaviour:
- Reset and synchronicity:
  - One clock; reset is synchronous and active-high.
  - On reset: FSM = IDLE; timeout=0, busy=0, remaining=0; prev_state register = 3'b000.
- FSM states: IDLE, RUN, PAUSED, DONE. The FSM is state-register based; all outputs are registered.
- Change detection:
  - chg = (state_in != prev_state).
  - prev_state <= state_in every non-reset cycle.
  - A state change has priority over pause, countdown and DONE hold, from any FSM state.
- Load, on an edge where chg=1 and TIMED_MASK[state_in]=1:
  - remaining <= (counts_num==0) ? 1 : counts_num.
  - busy <= 1; FSM <= RUN (or PAUSED if pause=1 on that edge).
- Untimed entry, on an edge where chg=1 and TIMED_MASK[state_in]=0:
  - FSM <= IDLE; remaining <= 0; busy <= 0; no timeout.
  - This aborts any countdown in progress.
- RUN, chg=0:
  - pause=1: FSM <= PAUSED; remaining holds.
  - pause=0 and remaining>1: remaining <= remaining-1.
  - pause=0 and remaining==1: remaining <= 0; timeout <= 1; busy <= 0; FSM <= DONE.
- PAUSED, chg=0:
  - remaining holds.
  - pause=0: FSM <= RUN. No decrement on the resume edge; decrement resumes on the following edge.
- DONE, chg=0: timeout <= 0 (pulse is exactly one cycle); hold until the next state change.
- IDLE, chg=0: hold, all outputs 0.
- Latency:
  - If counts_num=N is loaded at edge L with pause held low, timeout is high in the cycle following edge L+N.
  - Each pause cycle extends this by one cycle; each resume edge adds one further cycle.
- Timeout pulse rules:
  - timeout is never high for 2 consecutive cycles.
  - A state change on the same edge as expiry takes priority: reload or IDLE, and no timeout pulse.
- Same timed code re-entered via an intermediate code:
  - Each change is detected separately; the countdown reloads.
- Widths and arithmetic:
  - No wrap-around: the counter never decrements from 0.
  - counts_num is sampled only at load; later changes on it are ignored.
- Reset mid-countdown: immediate return to the reset values on that edge; a pending timeout is discarded.

Test Plan:
- Reset → outputs low: rst=1 for 2 cycles with state_in=3'b011 → timeout=0, busy=0, remaining=0.
- Basic countdown, release reset with state_in held at 3'b011:
  - prev_state=000 gives chg on the first edge; load 5.
  - Sequence: remaining 5,4,3,2,1,0; timeout high for exactly 1 cycle, 5 cycles after load; busy falls with timeout.
- Pause during countdown:
  - state_in 000→001, counts_num=10; pause=1 for 3 cycles after remaining=6.
  - remaining holds 6 throughout; timeout arrives 4 cycles later than the unpaused case (3 pause + 1 resume).
- Abort on phase change:
  - Load 8 on 011; at remaining=3 switch state_in to 110 with counts_num=4.
  - remaining reloads to 4; no timeout from the aborted count; timeout 4 cycles later.
- Untimed abort and zero count:
  - Switch to 000 mid-count → IDLE, remaining=0, no pulse.
  - Enter 111 with counts_num=0 → loads 1, timeout on the next edge.
- Collision and reset:
  - State change on the expiry edge → no timeout pulse, reload observed.
  - rst on the edge where remaining==1 → timeout stays 0, all outputs 0.

Source files
------------

// File: rtl/phase_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phase_timer_if                                                       |
// | Phase code / count / pause in, timeout / busy / remaining out.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface phase_timer_if #(
  parameter int unsigned CNT_W = 32
);
  logic [2:0]       state_in;
  logic [CNT_W-1:0] counts_num;
  logic             pause;
  logic             timeout;
  logic             busy;
  logic [CNT_W-1:0] remaining;

  modport master (
    output state_in, counts_num, pause,
    input  timeout, busy, remaining
  );

  modport slave (
    input  state_in, counts_num, pause,
    output timeout, busy, remaining
  );
endinterface
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phase_timer                                                          |
// | Loads a per-phase count on entry to a timed phase and counts it      |
// | down, with pause, returning a one-cycle timeout pulse.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module phase_timer #(
  parameter int unsigned CNT_W      = 32,
  parameter logic [7:0]  TIMED_MASK = 8'b1100_1010
) (
  input  logic        clk,
  input  logic        rst,
  phase_timer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_ZERO = '0;
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_prev;
  logic [CNT_W-1:0] r_remaining, w_remaining_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             w_chg;
  logic             w_timed;

  assign w_chg   = (bus.state_in != r_prev);
  assign w_timed = TIMED_MASK[bus.state_in];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prev      <= 3'b000;
      r_remaining <= c_ZERO;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= bus.state_in;
      r_remaining <= w_remaining_nxt;
      r_busy      <= w_busy_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_busy_nxt      = r_busy;
    w_timeout_nxt   = 1'b0;

    // A phase change overrides whatever the countdown was doing.
    if (w_chg) begin
      if (w_timed) begin
        w_remaining_nxt = (bus.counts_num == c_ZERO) ? c_ONE : bus.counts_num;
        w_busy_nxt      = 1'b1;
        w_state_nxt     = bus.pause ? S_PAUSED : S_RUN;
      end else begin
        w_remaining_nxt = c_ZERO;
        w_busy_nxt      = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (bus.pause) begin
            w_state_nxt = S_PAUSED;
          end else if (r_remaining > c_ONE) begin
            w_remaining_nxt = r_remaining - c_ONE;
          end else begin
            w_remaining_nxt = c_ZERO;
            w_timeout_nxt   = 1'b1;
            w_busy_nxt      = 1'b0;
            w_state_nxt     = S_DONE;
          end
        end
        // Resume edge only leaves PAUSED; counting restarts one edge later.
        S_PAUSED: begin
          if (!bus.pause) begin
            w_state_nxt = S_RUN;
          end
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.timeout   = r_timeout;
  assign bus.busy      = r_busy;
  assign bus.remaining = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_phase_timer                                                       |
// | Directed and random stimulus against a reference model of the timer. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_phase_timer;

  localparam int unsigned CNT_W = 32;
  localparam logic [7:0]  MASK  = 8'b1100_1010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Reference model: remaining time, whether a countdown is live, frozen flag.
  logic [2:0]       m_prev  = 3'b000;
  logic [CNT_W-1:0] m_left  = '0;
  logic             m_live  = 1'b0;
  logic             m_froz  = 1'b0;
  logic             m_to    = 1'b0;

  phase_timer_if #(.CNT_W(CNT_W)) bus ();

  phase_timer #(
    .CNT_W      (CNT_W),
    .TIMED_MASK (MASK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    m_to = 1'b0;
    if (rst) begin
      m_prev = 3'b000; m_left = '0; m_live = 1'b0; m_froz = 1'b0;
    end else begin
      if (bus.state_in != m_prev) begin
        if (MASK[bus.state_in]) begin
          m_left = (bus.counts_num == 0) ? 1 : bus.counts_num;
          m_live = 1'b1;
          m_froz = bus.pause;
        end else begin
          m_left = '0; m_live = 1'b0; m_froz = 1'b0;
        end
      end else if (m_live) begin
        if (m_froz) begin
          m_froz = bus.pause;
        end else if (bus.pause) begin
          m_froz = 1'b1;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_live = 1'b0;
            m_to   = 1'b1;
          end
        end
      end
      m_prev = bus.state_in;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("timeout",   {{(CNT_W-1){1'b0}}, bus.timeout}, {{(CNT_W-1){1'b0}}, m_to});
    check("busy",      {{(CNT_W-1){1'b0}}, bus.busy},    {{(CNT_W-1){1'b0}}, m_live});
    check("remaining", bus.remaining, m_left);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until timeout or the bound runs out; n returns the edges taken.
  task automatic wait_to(input int max, output int n);
    n = 0;
    while (!bus.timeout && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic set_phase(input logic [2:0] code, input int cnt);
    bus.state_in   = code;
    bus.counts_num = CNT_W'(cnt);
  endtask

  initial begin
    int n;
    int prev_to;
    bus.pause = 1'b0;
    set_phase(3'b011, 5);

    // Reset held two cycles with a timed phase present
    rst = 1'b1;
    ticks(2);
    check("rst_timeout",   {31'd0, bus.timeout}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy}, 32'd0);
    check("rst_remaining", bus.remaining, 32'd0);

    // Basic countdown of 5 after reset release
    rst = 1'b0;
    tick();
    check("basic_load", bus.remaining, 32'd5);
    check("basic_busy", {31'd0, bus.busy}, 32'd1);
    wait_to(20, n);
    check("basic_latency", n, 32'd5);
    check("basic_busy_fall", {31'd0, bus.busy}, 32'd0);
    tick();
    check("basic_one_pulse", {31'd0, bus.timeout}, 32'd0);

    // Pause of 3 cycles at remaining=6
    set_phase(3'b000, 0);
    tick();
    set_phase(3'b001, 10);
    tick();
    check("pause_load", bus.remaining, 32'd10);
    set_phase(3'b001, 99);
    ticks(4);
    check("pause_at6", bus.remaining, 32'd6);
    bus.pause = 1'b1;
    ticks(3);
    check("pause_hold", bus.remaining, 32'd6);
    bus.pause = 1'b0;
    tick();
    check("pause_resume_hold", bus.remaining, 32'd6);
    wait_to(40, n);
    check("pause_latency", 4 + 3 + 1 + n, 32'd14);

    // Abort by switching to another timed phase
    set_phase(3'b011, 8);
    tick();
    ticks(5);
    check("abort_at3", bus.remaining, 32'd3);
    set_phase(3'b110, 4);
    tick();
    check("abort_reload", bus.remaining, 32'd4);
    check("abort_no_pulse", {31'd0, bus.timeout}, 32'd0);
    wait_to(20, n);
    check("abort_latency", n, 32'd4);

    // Untimed abort mid-count
    set_phase(3'b011, 7);
    ticks(3);
    set_phase(3'b000, 7);
    tick();
    check("untimed_rem", bus.remaining, 32'd0);
    check("untimed_busy", {31'd0, bus.busy}, 32'd0);
    ticks(8);
    check("untimed_no_pulse", {31'd0, bus.timeout}, 32'd0);

    // Zero count loads 1 and expires on the next edge
    set_phase(3'b111, 0);
    tick();
    check("zero_load", bus.remaining, 32'd1);
    tick();
    check("zero_timeout", {31'd0, bus.timeout}, 32'd1);

    // Phase change on the expiry edge suppresses the pulse
    set_phase(3'b001, 3);
    ticks(3);
    check("coll_at1", bus.remaining, 32'd1);
    set_phase(3'b011, 6);
    tick();
    check("coll_no_pulse", {31'd0, bus.timeout}, 32'd0);
    check("coll_reload", bus.remaining, 32'd6);

    // Reset on the edge where remaining==1
    ticks(5);
    check("rst_at1", bus.remaining, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_timeout", {31'd0, bus.timeout}, 32'd0);
    check("rst_mid_rem", bus.remaining, 32'd0);
    ticks(2);
    check("rst_mid_quiet", {31'd0, bus.timeout}, 32'd0);
    rst = 1'b0;

    // Random phases, pauses, count noise and occasional reset
    prev_to = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0)
        set_phase(3'($urandom_range(0, 7)), int'($urandom_range(0, 12)));
      else if ($urandom_range(0, 5) == 0)
        bus.counts_num = CNT_W'($urandom_range(0, 50));
      bus.pause = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
      if (prev_to == 1)
        check("no_double_pulse", {31'd0, bus.timeout}, 32'd0);
      prev_to = int'(bus.timeout);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
